// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg: shared types and constants for the dmem_responder block.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int          CNT_W     = 4;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Misaligned, or beyond the last word of a DEPTH-word store.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] limit;
    limit = depth << 2;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// dmem_if: request/response bus between an initiator and dmem_responder.
// Optional macro: DMEM_BYTEMASK_EN adds the req_be byte-enable signal.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTEMASK_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
`ifdef DMEM_BYTEMASK_EN
    output req_be,
`endif
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
`ifdef DMEM_BYTEMASK_EN
    input  req_be,
`endif
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// dmem_array: word-wide storage, byte-lane write mask, registered read port.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_array #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data only moves on a read strobe so a pending response stays stable.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder: single-outstanding memory responder with WAIT wait states.
// Optional macro: DMEM_BYTEMASK_EN enables per-byte write masking via req_be.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_en_q, rdy_en_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
`ifdef DMEM_BYTEMASK_EN
  logic [3:0]       be_q, be_d;
`endif

  logic             accept;
  logic             commit;
  logic             op_we;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic [3:0]       op_be;
  logic             op_err;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;

  // With WAIT=0 the commit happens on the accept edge itself, so the
  // storage operation is taken straight from the bus while in IDLE.
  always_comb begin
    op_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    op_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    op_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
`ifdef DMEM_BYTEMASK_EN
    op_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
`else
    op_be    = 4'hF;
`endif
    op_err   = addr_err(op_addr, 32'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef DMEM_BYTEMASK_EN
    be_d     = be_q;
`endif
    commit   = 1'b0;
    accept   = (state_q == ST_IDLE) && rdy_en_q && bus.req_valid;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DMEM_BYTEMASK_EN
          be_d    = bus.req_be;
`endif
          if (WAIT == 0) begin
            state_d = ST_RESP;
            cnt_d   = '0;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    mem_we = commit && op_we && !op_err;
    mem_re = commit && !op_we && !op_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef DMEM_BYTEMASK_EN
      be_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef DMEM_BYTEMASK_EN
      be_q     <= be_d;
`endif
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (op_be),
    .idx   (op_addr[IDX_W+1:2]),
    .wdata (op_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  // Outputs derive from registered state only; op_* equals the capture in RESP.
  assign bus.req_ready = (state_q == ST_IDLE) && rdy_en_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) && op_err;
  assign bus.rsp_rdata = ((state_q == ST_RESP) && !we_q && !op_err) ? mem_rdata : ERR_RDATA;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int TB_WAIT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_if bus();

  dmem_responder #(
    .DEPTH (DEPTH),
    .WAIT  (TB_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: one transaction in flight; it becomes visible TB_WAIT cycles after
  // acceptance and leaves on the first edge that sees rsp_ready.
  logic        m_up    = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_we    = 1'b0;
  int          m_age   = 0;
  int          m_id    = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be    = 4'hF;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_up   <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      m_up <= 1'b1;
      if (!m_busy) begin
        if (m_up && bus.req_valid) begin
          m_busy  <= 1'b1;
          m_age   <= 0;
          m_id    <= m_id + 1;
          m_we    <= bus.req_we;
          m_addr  <= bus.req_addr;
          m_wdata <= bus.req_wdata;
`ifdef DMEM_BYTEMASK_EN
          m_be    <= bus.req_be;
`else
          m_be    <= 4'hF;
`endif
        end
      end else if (m_age >= TB_WAIT) begin
        if (bus.rsp_ready) m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  logic [31:0] m_mem [DEPTH];
  int          done_id   = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
    end else begin
      check("req_ready", {31'b0, bus.req_ready}, {31'b0, m_up && !m_busy});
      check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_busy && (m_age >= TB_WAIT)});
      if (m_busy && (m_age >= TB_WAIT)) begin
        if (done_id != m_id) begin
          done_id   = m_id;
          exp_err   = (m_addr % 4 != 0) || (m_addr >= DEPTH * 4);
          exp_rdata = '0;
          if (!exp_err) begin
            if (m_we) begin
              for (int b = 0; b < 4; b++)
                if (m_be[b]) m_mem[m_addr / 4][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
              exp_rdata = m_mem[m_addr / 4];
            end
          end
        end
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
      end
    end
  end

  // One transaction; hold>0 keeps rsp_ready low for hold extra RESP cycles.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
`ifdef DMEM_BYTEMASK_EN
    bus.req_be    = be;
`endif
    bus.rsp_ready = (hold == 0);
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = 32'h5A5A_5A5A;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (!bus.rsp_valid) begin
      check("rsp_timeout", {31'b0, bus.rsp_valid}, 32'd1);
      bus.rsp_ready = 1'b1;
      return;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rdata", bus.rsp_rdata, rdata);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef DMEM_BYTEMASK_EN
    bus.req_be    = 4'hF;
`endif
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lt);
    check("wr_latency", lt, TB_WAIT + 1);
    check("wr_err", {31'b0, er}, 32'd0);
    check("wr_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lt);
    check("rd_0x10", rd, 32'hDEAD_BEEF);
    check("rd_latency", lt, TB_WAIT + 1);

    txn(1'b1, 32'h00, 32'hA5A5_0001, 4'hF, 0, rd, er, lt);
    txn(1'b1, 32'hFC, 32'h0BAD_F00D, 4'hF, 0, rd, er, lt);
    txn(1'b0, 32'hFC, 32'h0, 4'hF, 0, rd, er, lt);
    check("rd_last_word", rd, 32'h0BAD_F00D);

    txn(1'b0, 32'h102, 32'h0, 4'hF, 0, rd, er, lt);
    check("misalign_err", {31'b0, er}, 32'd1);
    check("misalign_rdata", rd, 32'd0);
    txn(1'b0, 32'h100, 32'h0, 4'hF, 0, rd, er, lt);
    check("range_err", {31'b0, er}, 32'd1);
    check("range_rdata", rd, 32'd0);
    txn(1'b1, 32'h100, 32'h5555_5555, 4'hF, 0, rd, er, lt);
    check("range_wr_err", {31'b0, er}, 32'd1);
    txn(1'b1, 32'h12, 32'h6666_6666, 4'hF, 0, rd, er, lt);
    check("misalign_wr_err", {31'b0, er}, 32'd1);
    txn(1'b0, 32'h00, 32'h0, 4'hF, 0, rd, er, lt);
    check("no_alias_0x00", rd, 32'hA5A5_0001);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lt);
    check("unchanged_0x10", rd, 32'hDEAD_BEEF);

    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lt);
    check("hold_first_rdata", rd, 32'hDEAD_BEEF);
    check("idle_after_hold", {31'b0, bus.req_ready}, 32'd1);

    // Reset while a write is still in its wait states.
    txn(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, er, lt);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mid_rdata", bus.rsp_rdata, 32'd0);
    #2 reset = 1'b1;
    repeat (TB_WAIT + 3) @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lt);
    check("rst_no_commit", rd, (TB_WAIT == 0) ? 32'h1234_5678 : 32'h0);

`ifdef DMEM_BYTEMASK_EN
    txn(1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lt);
    txn(1'b1, 32'h30, 32'h0000_0000, 4'b0101, 0, rd, er, lt);
    txn(1'b0, 32'h30, 32'h0, 4'b0000, 0, rd, er, lt);
    check("bytemask", rd, 32'hFF00_FF00);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
